// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// Start/Busy/Done handshake; requests with any digit > 9 finish early with Err set.
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   BCD_In,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [BIN_W-1:0]      Bin_Out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [BIN_W-1:0] bin_out_q, bin_out_d;

  logic             in_bad;
  logic [BCD_W-1:0] bcd_sh;
  logic [BIN_W-1:0] bin_sh;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (BCD_In[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull any digit >= 8 down by 3.
  always_comb begin
    {bcd_sh, bin_sh} = {bcd_q, bin_q} >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sh[4*i+3]) bcd_sh[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bad_d     = bad_q;
    err_d     = err_q;
    bin_out_d = bin_out_q;
    // Status outputs trail the state by one edge so they are purely registered.
    busy_d    = (state_q != S_IDLE);
    done_d    = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          bin_d = '0;
          cnt_d = '0;
          if (in_bad) begin
            bcd_d   = '0;
            bad_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            bcd_d   = BCD_In;
            bad_d   = 1'b0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_DONE;
      end
      S_DONE: begin
        bin_out_d = bin_q;
        err_d     = bad_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bad_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bad_q     <= bad_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      bin_out_q <= bin_out_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign Bin_Out = bin_out_q;

endmodule
